// File: rtl/vbcal_pkg.sv
// vbcal_pkg: shared state enum, tune width and default timing constants for VCO band calibration
package vbcal_pkg;
  localparam int TUNE_W = 5;
  localparam int SETTLE_DEF = 64;
  localparam int WINDOW_DEF = 1024;
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_COUNT, S_DECIDE, S_DONE} vbcal_state_t;
endpackage

// File: rtl/vbcal_win_cnt.sv
// vbcal_win_cnt: saturating windowed tick counter (clear wins over enable)
module vbcal_win_cnt #(
  parameter int W = 16
) (
  input  logic         refclk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         tick_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (en_i && tick_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge refclk)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/vco_band_cal.sv
// vco_band_cal: MSB-first successive-approximation coarse band calibration of a VCO tune word.
// Optional macro VBCAL_RANGE_ERR_EN adds the cal_err out-of-range flag.
module vco_band_cal
  import vbcal_pkg::*;
#(
  parameter logic [TUNE_W-1:0] TUNE_RST   = 5'b01111,
  parameter int                CNT_W      = 16,
  parameter int                SETTLE_CYC = SETTLE_DEF,
  parameter int                WINDOW_CYC = WINDOW_DEF
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              vco_tick,
  input  logic [CNT_W-1:0]  target_cnt,
  output logic [TUNE_W-1:0] tune,
  output logic              vctrl_hold,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  last_cnt
`ifdef VBCAL_RANGE_ERR_EN
  ,
  output logic              cal_err
`endif
);
  localparam int CYC_W = $clog2(WINDOW_CYC > SETTLE_CYC ? WINDOW_CYC : SETTLE_CYC) + 1;
  vbcal_state_t state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [2:0] idx_q, idx_d;
  logic [TUNE_W-1:0] tune_q, tune_d;
  logic [CNT_W-1:0] tgt_q, tgt_d, last_q, last_d, cnt;
  logic busy_q, busy_d, done_q, done_d, blk_q;
  vbcal_win_cnt #(.W(CNT_W)) u_cnt (
    .refclk(refclk),
    .rst_n (rst_n),
    .clr_i (state_q == S_SETTLE),
    .en_i  (state_q == S_COUNT),
    .tick_i(vco_tick),
    .cnt_o (cnt)
  );
`ifdef VBCAL_RANGE_ERR_EN
  logic err_q, err_d;
  always_comb begin
    err_d = err_q;
    if (state_q == S_IDLE && start && !blk_q) err_d = 1'b0;
    if (state_q == S_DONE)
      err_d = (tune_q == '1 && last_q < tgt_q) || (tune_q == '0 && last_q > tgt_q);
  end
  always_ff @(posedge refclk)
    if (!rst_n) err_q <= 1'b0;
    else err_q <= err_d;
  assign cal_err = err_q;
`endif
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q + 1'b1;
    idx_d   = idx_q;
    tune_d  = tune_q;
    tgt_d   = tgt_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        cyc_d = '0;
        if (start && !blk_q) begin
          tgt_d   = target_cnt;
          idx_d   = 3'd4;
          tune_d  = 5'b10000;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: if (cyc_q == CYC_W'(SETTLE_CYC - 1)) begin
        cyc_d   = '0;
        state_d = S_COUNT;
      end
      S_COUNT: if (cyc_q == CYC_W'(WINDOW_CYC - 1)) begin
        cyc_d   = '0;
        state_d = S_DECIDE;
      end
      S_DECIDE: begin
        cyc_d  = '0;
        last_d = cnt;
        if (cnt > tgt_q) tune_d[idx_q] = 1'b0;
        if (idx_q != 3'd0) begin
          tune_d[idx_q - 3'd1] = 1'b1;
          idx_d   = idx_q - 3'd1;
          state_d = S_SETTLE;
        end else state_d = S_DONE;
      end
      S_DONE: begin
        cyc_d   = '0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // blk_q masks start during the first IDLE cycle after DONE, when done has just risen
  always_ff @(posedge refclk)
    if (!rst_n) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      idx_q   <= '0;
      tune_q  <= TUNE_RST;
      tgt_q   <= '0;
      last_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      blk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      idx_q   <= idx_d;
      tune_q  <= tune_d;
      tgt_q   <= tgt_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      blk_q   <= state_q == S_DONE;
    end
  assign tune       = tune_q;
  assign busy       = busy_q;
  assign vctrl_hold = busy_q;
  assign done       = done_q;
  assign last_cnt   = last_q;
endmodule

// File: tb/tb_vco_band_cal.sv
// tb_vco_band_cal: random-target bench against an ideal VCO model (10*tune+20 ticks per window)
module tb_vco_band_cal;
  localparam int LAT = 5 * (64 + 1024 + 1) + 1;
  logic refclk = 1'b0, rst_n = 1'b0, start = 1'b0, vco_tick = 1'b0;
  logic [15:0] target_cnt = '0, last_cnt;
  logic [4:0] tune;
  logic vctrl_hold, busy, done;
  logic s_start = 1'b0;
  logic [3:0] s_target = 4'd3, s_last;
  logic [4:0] s_tune;
  logic s_hold, s_busy, s_done;
  int total = 0, bad = 0, acc = 0;
`ifdef VBCAL_RANGE_ERR_EN
  logic cal_err, s_err;
`endif
  always #5 refclk = ~refclk;
  vco_band_cal dut (
    .refclk(refclk), .rst_n(rst_n), .start(start), .vco_tick(vco_tick),
    .target_cnt(target_cnt), .tune(tune), .vctrl_hold(vctrl_hold),
    .busy(busy), .done(done), .last_cnt(last_cnt)
`ifdef VBCAL_RANGE_ERR_EN
    , .cal_err(cal_err)
`endif
  );
  vco_band_cal #(.CNT_W(4), .SETTLE_CYC(4), .WINDOW_CYC(32)) dut_sat (
    .refclk(refclk), .rst_n(rst_n), .start(s_start), .vco_tick(1'b1),
    .target_cnt(s_target), .tune(s_tune), .vctrl_hold(s_hold),
    .busy(s_busy), .done(s_done), .last_cnt(s_last)
`ifdef VBCAL_RANGE_ERR_EN
    , .cal_err(s_err)
`endif
  );
  // evenly spaced ticks: exactly 10*tune+20 ticks in any 1024-cycle span of constant tune
  always @(negedge refclk) begin
    acc = acc + 10 * int'(tune) + 20;
    vco_tick = acc >= 1024;
    if (vco_tick) acc = acc - 1024;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int ref_tune(input int tgt);
    int best = 0;
    for (int c = 0; c < 32; c++) if (10 * c + 20 <= tgt) best = c;
    return best;
  endfunction
  task automatic run_cal(input int tgt, input bit poke);
    int n = 0, et, el;
    @(negedge refclk);
    target_cnt = 16'(tgt);
    start = 1'b1;
    @(posedge refclk); #1;
    start = 1'b0;
    chk("busy_rise", busy, 1);
    chk("hold_rise", vctrl_hold, 1);
    chk("done_clr", done, 0);
    chk("trial_msb", tune, 16);
    while (n < LAT + 100) begin
      @(posedge refclk); #1;
      n++;
      if (poke && n == 3000) begin start = 1'b1; target_cnt = 16'd7; end
      if (poke && n == 3001) start = 1'b0;
      if (done) break;
    end
    et = ref_tune(tgt);
    el = 10 * (et | 1) + 20;
    chk("latency", n, LAT);
    chk("tune", tune, et);
    chk("last_cnt", last_cnt, el);
    chk("busy_fall", busy, 0);
    chk("hold_fall", vctrl_hold, 0);
`ifdef VBCAL_RANGE_ERR_EN
    chk("cal_err", cal_err, ((et == 31 && el < tgt) || (et == 0 && el > tgt)) ? 1 : 0);
`endif
    start = 1'b1;
    @(posedge refclk); #1;
    start = 1'b0;
    chk("start_blocked", busy, 0);
    chk("done_level", done, 1);
    chk("tune_hold", tune, et);
  endtask
  initial begin
    int n;
    repeat (3) @(posedge refclk);
    #1;
    chk("rst_tune", tune, 15);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hold", vctrl_hold, 0);
    chk("rst_last", last_cnt, 0);
    @(negedge refclk);
    rst_n = 1'b1;
    s_start = 1'b1;
    @(negedge refclk);
    s_start = 1'b0;
    n = 0;
    while (!s_done && n < 1000) begin @(posedge refclk); #1; n++; end
    chk("sat_done", s_done, 1);
    chk("sat_last", s_last, 15);
    chk("sat_tune", s_tune, 0);
    run_cal(175, 1'b0);
    run_cal(200, 1'b1);
    run_cal(1000, 1'b0);
    run_cal(5, 1'b0);
    for (int i = 0; i < 3; i++) run_cal(int'($urandom_range(0, 400)), 1'b0);
    @(negedge refclk);
    target_cnt = 16'd175;
    start = 1'b1;
    @(negedge refclk);
    start = 1'b0;
    repeat (2 * 1089 + 64 + 200) @(posedge refclk);
    #1;
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge refclk); #1;
    chk("abort_tune", tune, 15);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_hold", vctrl_hold, 0);
    chk("abort_last", last_cnt, 0);
    rst_n = 1'b1;
    run_cal(int'($urandom_range(0, 400)), 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
